// File: rtl/mha_pkg.sv
// Shared fixed-point definitions for the multi-head-attention stages.
//   D_W / FRAC : default data width and fractional bits (16b -> Q2.13)
//   fx_t       : signed fixed-point sample type
//   state_t    : sequencing states of the attention-times-V stage
//   round_sat  : round half-up on the FRAC LSBs, then saturate to dw bits
package mha_pkg;

  localparam int D_W  = 16;
  localparam int FRAC = (D_W == 16) ? 13 : 5;

  typedef logic signed [D_W-1:0] fx_t;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    DRAIN,
    OUT,
    DONE
  } state_t;

  // Works on a 64-bit sign-extended accumulator so any stage width fits;
  // the caller truncates the result to its own data width.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int unsigned dw,
                                                   input int unsigned frac);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/attn_v_matmul_if.sv
// Handshake/data bundle between the softmax row source, the V row streamer
// and the attention-times-V stage.
//   I_START  : level, held for the whole operation
//   I_P      : probability row, NUM entries of D_W bits
//   I_V_VLD  : V row beat valid
//   I_V_ROW  : V row, DIM entries of D_W bits
//   O_V_RDY  : stage accepts a V beat
//   O_VLD    : result row valid (level)
//   O_DATA   : result row, DIM entries of D_W bits
interface attn_v_matmul_if #(
  parameter int D_W = 16,
  parameter int NUM = 16,
  parameter int DIM = 16
);
  logic                      I_START;
  logic [NUM-1:0][D_W-1:0]   I_P;
  logic                      I_V_VLD;
  logic [DIM-1:0][D_W-1:0]   I_V_ROW;
  logic                      O_V_RDY;
  logic                      O_VLD;
  logic [DIM-1:0][D_W-1:0]   O_DATA;

  modport master (
    output I_START, I_P, I_V_VLD, I_V_ROW,
    input  O_V_RDY, O_VLD, O_DATA
  );

  modport slave (
    input  I_START, I_P, I_V_VLD, I_V_ROW,
    output O_V_RDY, O_VLD, O_DATA
  );
endinterface

// File: rtl/attn_v_lane.sv
// One output column of the attention-times-V product.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clears product pipeline and accumulator
//   en         : a V beat transfers this cycle; registers p*v
//   p, v       : selected probability and this column's V element
//   acc        : running full-precision sum
module attn_v_lane #(
  parameter int D_W   = 16,
  parameter int ACC_W = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [D_W-1:0]   p,
  input  logic signed [D_W-1:0]   v,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*D_W-1:0] prod;
  logic                    prod_vld;

  // Product is registered on the transfer edge and folded into the sum on
  // the following edge, so the last beat needs one extra drain cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else if (clr) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= en;
      if (en) prod <= p * v;
      if (prod_vld) acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/attn_v_matmul.sv
// Attention-times-V stage: O[j] = sum_k P[k]*V[k][j], rounded and saturated.
// V arrives one row per accepted beat; the row index comes from the beat counter.
//   I_CLK   : clock, rising edge
//   I_RST_N : asynchronous active-low reset
//   bus     : slave side of attn_v_matmul_if (start, P row, V stream, result)
module attn_v_matmul
  import mha_pkg::*;
#(
  parameter int D_W  = mha_pkg::D_W,
  parameter int FRAC = mha_pkg::FRAC,
  parameter int NUM  = 16,
  parameter int DIM  = 16
) (
  input  logic             I_CLK,
  input  logic             I_RST_N,
  attn_v_matmul_if.slave   bus
);

  localparam int ACC_W = 2*D_W + $clog2(NUM);
  localparam int CNT_W = $clog2(NUM);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     v_rdy;
  logic                     o_vld;
  logic [DIM-1:0][D_W-1:0]  o_data;

  logic                     xfer;
  logic                     clr;
  logic signed [D_W-1:0]    p_sel;
  logic signed [ACC_W-1:0]  acc [DIM];

  assign xfer  = bus.I_V_VLD & v_rdy;
  // Lanes clear on the same edge the operation starts.
  assign clr   = (state == IDLE) & bus.I_START;
  assign p_sel = bus.I_P[cnt];

  for (genvar j = 0; j < DIM; j++) begin : g_lane
    attn_v_lane #(
      .D_W   (D_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (I_CLK),
      .rst_n (I_RST_N),
      .clr   (clr),
      .en    (xfer),
      .p     (p_sel),
      .v     (bus.I_V_ROW[j]),
      .acc   (acc[j])
    );
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      v_rdy  <= 1'b0;
      o_vld  <= 1'b0;
      o_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.I_START) begin
            state <= ACC;
            cnt   <= '0;
            v_rdy <= 1'b1;
          end
        end
        ACC: begin
          if (!bus.I_START) begin
            state <= IDLE;
            v_rdy <= 1'b0;
          end else if (xfer) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(NUM - 1)) begin
              state <= DRAIN;
              v_rdy <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state <= bus.I_START ? OUT : IDLE;
        end
        OUT: begin
          if (!bus.I_START) begin
            state <= IDLE;
          end else begin
            for (int unsigned j = 0; j < DIM; j++) begin
              o_data[j] <= D_W'(round_sat(64'(acc[j]), D_W, FRAC));
            end
            o_vld <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!bus.I_START) begin
            state <= IDLE;
            o_vld <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          v_rdy <= 1'b0;
          o_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.O_V_RDY = v_rdy;
  assign bus.O_VLD   = o_vld;
  assign bus.O_DATA  = o_data;

endmodule
